// File: rtl/reg_file_rename.sv
// ----------------------------------------------------------------------------
// reg_file_rename
//
// Architectural register file with rename-tag tracking. It sits directly
// downstream of the reorder buffer.
//
// Each of the 32 architectural registers holds:
//   - a committed 32-bit value,
//   - a busy flag, set while an in-flight instruction still owes the register
//     a result,
//   - the ROB id of that producer.
// Register 0 is hard-wired to zero and is never busy.
//
// Ports:
//   clk_in             system clock; all state updates on the rising edge
//   rst_in             synchronous active-low reset; overrides everything,
//                      including rdy_in
//   rdy_in             global ready; state holds while low
//   clear              pipeline flush: drops every pending tag and keeps values
//   set_reg_id         commit destination register (0 = no commit)
//   set_val            commit value
//   set_reg_on_rob_id  ROB id of the committing entry
//   set_dep_reg_id     rename destination register (0 = no rename)
//   set_dep_rob_id     ROB id allocated to the renamed register
//   rs1_id / rs2_id    operand query indices
//   rsN_val            operand value (meaningful when rsN_busy = 0)
//   rsN_busy           operand still awaits an in-flight producer
//   rsN_rob_id         producer ROB id (0 when not busy)
// ----------------------------------------------------------------------------
module reg_file_rename #(
    parameter int unsigned ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [4:0]               set_reg_id,
    input  logic [31:0]              set_val,
    input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
    input  logic [4:0]               set_dep_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
    input  logic [4:0]               rs1_id,
    input  logic [4:0]               rs2_id,
    output logic [31:0]              rs1_val,
    output logic                     rs1_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_rob_id,
    output logic [31:0]              rs2_val,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs2_rob_id
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]              r_val [32];
    logic [31:0]              r_busy;
    logic [ROB_WIDTH_BIT-1:0] r_dep [32];

    logic [31:0]              w_val_d [32];
    logic [31:0]              w_busy_d;
    logic [ROB_WIDTH_BIT-1:0] w_dep_d [32];

    logic                     w_commit;
    logic                     w_rename;
    logic                     w_commit_match;

    assign w_commit = (set_reg_id != 5'd0);
    assign w_rename = (set_dep_reg_id != 5'd0);

    // A commit releases the register only when it comes from the producer that
    // is currently recorded. An older producer retiring after a newer rename
    // must leave that rename pending.
    assign w_commit_match = w_commit && r_busy[set_reg_id]
                            && (r_dep[set_reg_id] == set_reg_on_rob_id);

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_val_d[i] = r_val[i];
            w_dep_d[i] = r_dep[i];
        end
        w_busy_d = r_busy;

        if (rdy_in) begin
            if (w_commit) begin
                w_val_d[set_reg_id] = set_val;
                if (w_commit_match) begin
                    w_busy_d[set_reg_id] = 1'b0;
                end
            end

            // A flush discards the same-cycle rename. The committed value
            // written above is kept.
            if (clear) begin
                w_busy_d = '0;
                for (int i = 0; i < 32; i++) begin
                    w_dep_d[i] = '0;
                end
            end else if (w_rename) begin
                // The rename is applied after the commit, so it wins on the
                // same register.
                w_busy_d[set_dep_reg_id] = 1'b1;
                w_dep_d[set_dep_reg_id]  = set_dep_rob_id;
            end
        end

        // x0 stays constant whatever the requests carry.
        w_val_d[0]  = '0;
        w_busy_d[0] = 1'b0;
        w_dep_d[0]  = '0;
    end

    // ------------------------------------------------------------------------
    // State registers (synchronous active-low reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < 32; i++) begin
                r_val[i] <= '0;
                r_dep[i] <= '0;
            end
        end else begin
            r_busy <= w_busy_d;
            for (int i = 0; i < 32; i++) begin
                r_val[i] <= w_val_d[i];
                r_dep[i] <= w_dep_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operand queries
    // ------------------------------------------------------------------------
    // The commit bypass lets the decoder see a value that is retiring this
    // cycle. The same-cycle rename is deliberately invisible here.
    logic w_rs1_bypass;
    logic w_rs2_bypass;

    assign w_rs1_bypass = rdy_in && (rs1_id != 5'd0) && (set_reg_id == rs1_id)
                          && r_busy[rs1_id] && (r_dep[rs1_id] == set_reg_on_rob_id);
    assign w_rs2_bypass = rdy_in && (rs2_id != 5'd0) && (set_reg_id == rs2_id)
                          && r_busy[rs2_id] && (r_dep[rs2_id] == set_reg_on_rob_id);

    always_comb begin
        rs1_val    = '0;
        rs1_busy   = 1'b0;
        rs1_rob_id = '0;
        if (rs1_id == 5'd0) begin
            rs1_val    = '0;
        end else if (w_rs1_bypass) begin
            rs1_val    = set_val;
        end else begin
            rs1_val    = r_val[rs1_id];
            rs1_busy   = r_busy[rs1_id];
            rs1_rob_id = r_busy[rs1_id] ? r_dep[rs1_id] : '0;
        end
    end

    always_comb begin
        rs2_val    = '0;
        rs2_busy   = 1'b0;
        rs2_rob_id = '0;
        if (rs2_id == 5'd0) begin
            rs2_val    = '0;
        end else if (w_rs2_bypass) begin
            rs2_val    = set_val;
        end else begin
            rs2_val    = r_val[rs2_id];
            rs2_busy   = r_busy[rs2_id];
            rs2_rob_id = r_busy[rs2_id] ? r_dep[rs2_id] : '0;
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;
    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic [4:0]    set_reg_id;
    logic [31:0]   set_val;
    logic [RW-1:0] set_reg_on_rob_id;
    logic [4:0]    set_dep_reg_id;
    logic [RW-1:0] set_dep_rob_id;
    logic [4:0]    rs1_id;
    logic [4:0]    rs2_id;
    logic [31:0]   rs1_val;
    logic          rs1_busy;
    logic [RW-1:0] rs1_rob_id;
    logic [31:0]   rs2_val;
    logic          rs2_busy;
    logic [RW-1:0] rs2_rob_id;

    always #5 clk_in = ~clk_in;

    reg_file_rename #(.ROB_WIDTH_BIT(RW)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear             (clear),
        .set_reg_id        (set_reg_id),
        .set_val           (set_val),
        .set_reg_on_rob_id (set_reg_on_rob_id),
        .set_dep_reg_id    (set_dep_reg_id),
        .set_dep_rob_id    (set_dep_rob_id),
        .rs1_id            (rs1_id),
        .rs2_id            (rs2_id),
        .rs1_val           (rs1_val),
        .rs1_busy          (rs1_busy),
        .rs1_rob_id        (rs1_rob_id),
        .rs2_val           (rs2_val),
        .rs2_busy          (rs2_busy),
        .rs2_rob_id        (rs2_rob_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: committed value per register and the outstanding
    // producer tag, -1 meaning nothing is outstanding.
    logic [31:0] m_val [32];
    int          m_tag [32];

    function automatic void model_query(input logic [4:0] r, output logic [31:0] v,
                                        output logic b, output logic [RW-1:0] id);
        v = '0; b = 1'b0; id = '0;
        if (r != 0) begin
            if (rdy_in && set_reg_id == r && m_tag[r] == int'(set_reg_on_rob_id)) begin
                v = set_val;
            end else begin
                v = m_val[r];
                b = (m_tag[r] >= 0);
                if (b) id = RW'(m_tag[r]);
            end
        end
    endfunction

    function automatic void model_update();
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_tag[i] = -1; end
        end else if (rdy_in) begin
            if (set_reg_id != 0) begin
                m_val[set_reg_id] = set_val;
                if (m_tag[set_reg_id] == int'(set_reg_on_rob_id)) m_tag[set_reg_id] = -1;
            end
            if (clear) begin
                for (int i = 0; i < 32; i++) m_tag[i] = -1;
            end else if (set_dep_reg_id != 0) begin
                m_tag[set_dep_reg_id] = int'(set_dep_rob_id);
            end
        end
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        logic [31:0] v; logic b; logic [RW-1:0] id;
        model_query(rs1_id, v, b, id);
        cmp({tag, ".rs1_val"}, rs1_val, v);
        cmp({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(b));
        cmp({tag, ".rs1_rob"}, 32'(rs1_rob_id), 32'(id));
        model_query(rs2_id, v, b, id);
        cmp({tag, ".rs2_val"}, rs2_val, v);
        cmp({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(b));
        cmp({tag, ".rs2_rob"}, 32'(rs2_rob_id), 32'(id));
    endtask

    // Constant expectation on port 1, independent of the model.
    task automatic expect1(input string tag, input logic [31:0] v, input logic b,
                           input logic [RW-1:0] id);
        cmp({tag, ".val"}, rs1_val, v);
        cmp({tag, ".busy"}, 32'(rs1_busy), 32'(b));
        cmp({tag, ".rob"}, 32'(rs1_rob_id), 32'(id));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_update();
        @(negedge clk_in);
    endtask

    task automatic step(input string tag);
        #1;
        check_ports(tag);
        tick();
    endtask

    task automatic idle();
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
        set_reg_id = '0; set_val = '0; set_reg_on_rob_id = '0;
        set_dep_reg_id = '0; set_dep_rob_id = '0;
    endtask

    initial begin
        logic [4:0] r;
        for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_tag[i] = -1; end
        idle();
        rs1_id = 5'd5; rs2_id = 5'd0;
        @(negedge clk_in);

        // Reset
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        #1;
        expect1("rst_x5", 32'h0, 1'b0, '0);
        cmp("rst_x0.val", rs2_val, 32'h0);

        // Commit to x0 has no effect
        set_reg_id = 5'd0; set_val = 32'hFFFF_FFFF; rs1_id = 5'd0;
        step("x0_write");
        idle();
        #1 expect1("x0_after", 32'h0, 1'b0, '0);

        // Rename then matching commit with bypass
        set_dep_reg_id = 5'd3; set_dep_rob_id = 4'd6;
        step("ren_x3");
        idle(); rs1_id = 5'd3;
        #1 expect1("x3_busy", 32'h0, 1'b1, 4'd6);
        set_reg_id = 5'd3; set_val = 32'h1234; set_reg_on_rob_id = 4'd6;
        #1 expect1("x3_bypass", 32'h1234, 1'b0, '0);
        step("commit_x3");
        idle();
        #1 expect1("x3_stored", 32'h1234, 1'b0, '0);

        // Stale commit leaves the newer rename pending
        set_dep_reg_id = 5'd4; set_dep_rob_id = 4'd2; step("ren_x4_2");
        set_dep_reg_id = 5'd4; set_dep_rob_id = 4'd5; step("ren_x4_5");
        idle(); set_reg_id = 5'd4; set_val = 32'hAA; set_reg_on_rob_id = 4'd2;
        step("stale_x4");
        idle(); rs1_id = 5'd4;
        #1 expect1("x4_stale", 32'hAA, 1'b1, 4'd5);

        // Same-cycle commit and rename on x7
        set_dep_reg_id = 5'd7; set_dep_rob_id = 4'd1; step("ren_x7_1");
        idle();
        set_reg_id = 5'd7; set_val = 32'h77; set_reg_on_rob_id = 4'd1;
        set_dep_reg_id = 5'd7; set_dep_rob_id = 4'd9;
        step("commit_ren_x7");
        idle(); rs1_id = 5'd7;
        #1 expect1("x7_both", 32'h77, 1'b1, 4'd9);

        // Flush with concurrent commit and rename
        for (int i = 1; i <= 8; i++) begin
            set_dep_reg_id = 5'(i); set_dep_rob_id = 4'(i + 7);
            step("ren_bulk");
        end
        idle(); clear = 1'b1;
        set_reg_id = 5'd2; set_val = 32'h55; set_reg_on_rob_id = 4'd0;
        set_dep_reg_id = 5'd10; set_dep_rob_id = 4'd3;
        step("clear");
        idle();
        for (int i = 1; i <= 10; i++) begin
            rs1_id = 5'(i);
            #1 cmp("clear_busy", 32'(rs1_busy), 32'h0);
        end
        rs1_id = 5'd2;
        #1 expect1("x2_after_clear", 32'h55, 1'b0, '0);

        // Hold while not ready, then reset while not ready
        set_dep_reg_id = 5'd6; set_dep_rob_id = 4'd4; step("ren_x6");
        idle(); rdy_in = 1'b0;
        set_reg_id = 5'd6; set_val = 32'hDEAD; set_reg_on_rob_id = 4'd4;
        set_dep_reg_id = 5'd9; set_dep_rob_id = 4'd7;
        rs1_id = 5'd6; rs2_id = 5'd9;
        step("hold");
        idle(); rs1_id = 5'd6;
        #1 expect1("x6_held", 32'h0, 1'b1, 4'd4);
        rs1_id = 5'd9;
        #1 expect1("x9_held", 32'h0, 1'b0, '0);
        rdy_in = 1'b0; rst_in = 1'b0;
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_id = 5'(i);
            #1 expect1("rst_norey", 32'h0, 1'b0, '0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 500; n++) begin
            idle();
            rst_in = ($urandom_range(0, 99) != 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r = 5'($urandom_range(0, 7));
                set_reg_id = r; set_val = $urandom();
                if (m_tag[r] >= 0 && $urandom_range(0, 2) != 0)
                    set_reg_on_rob_id = RW'(m_tag[r]);
                else
                    set_reg_on_rob_id = RW'($urandom());
            end
            if ($urandom_range(0, 1) == 1) begin
                set_dep_reg_id = 5'($urandom_range(0, 7));
                set_dep_rob_id = RW'($urandom());
            end
            rs1_id = ($urandom_range(0, 1) == 1) ? set_reg_id : 5'($urandom_range(0, 31));
            rs2_id = ($urandom_range(0, 3) == 0) ? rs1_id : 5'($urandom_range(0, 9));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
